// File: rtl/wb_b3_pkg.sv
// rtl/wb_b3_pkg.sv - Wishbone B3 cycle-type encodings and burst master state enum
package wb_b3_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        GAP
    } state_t;

endpackage

// File: rtl/wb_b3_burst_master.sv
// rtl/wb_b3_burst_master.sv - command/stream to Wishbone B3 linear incrementing burst master
module wb_b3_burst_master
    import wb_b3_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int CNT_W     = 16,
    parameter int BURST_LEN = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [AW-1:0]     cmd_adr_i,
    input  logic [CNT_W-1:0]  cmd_len_i,
    input  logic [DW-1:0]     wr_data_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    output logic [DW-1:0]     rd_data_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic              done_o,
    output logic              err_o,
    output logic [AW-1:0]     wb_adr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic              wb_we_o,
    output logic [1:0]        wb_bte_o,
    output logic [2:0]        wb_cti_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic [DW-1:0]     wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_rty_i
);

    localparam int               BW          = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

    state_t           state_q, state_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [AW-1:0]    adr_q, adr_d;
    logic [2:0]       cti_q, cti_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic [BW-1:0]    beat_q, beat_d;

    logic stb;
    logic bus_fault;
    logic beat_ok;
    logic unused_adr_lsb;

    assign unused_adr_lsb = ^cmd_adr_i[1:0];

    function automatic logic [BW-1:0] burst_beats(input logic [CNT_W-1:0] n);
        return (n > BURST_LEN_C) ? BW'(BURST_LEN) : BW'(n);
    endfunction

    // A one-word burst is issued as a classic cycle rather than an incrementing burst.
    function automatic logic [2:0] first_cti(input logic [BW-1:0] nb);
        return (nb == BW'(1)) ? CTI_CLASSIC : CTI_INCR;
    endfunction

    assign stb       = cyc_q & (we_q ? wr_valid_i : rd_ready_i);
    assign bus_fault = cyc_q & (wb_err_i | wb_rty_i);
    assign beat_ok   = stb & wb_ack_i & ~bus_fault;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            adr_q   <= '0;
            cti_q   <= CTI_CLASSIC;
            words_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
            adr_q   <= adr_d;
            cti_q   <= cti_d;
            words_q <= words_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        done_d  = 1'b0;
        err_d   = err_q;
        adr_d   = adr_q;
        cti_d   = cti_q;
        words_d = words_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    err_d   = 1'b0;
                    we_d    = cmd_we_i;
                    adr_d   = {cmd_adr_i[AW-1:2], 2'b00};
                    words_d = cmd_len_i;
                    if (cmd_len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        beat_d  = burst_beats(cmd_len_i);
                        cti_d   = first_cti(burst_beats(cmd_len_i));
                        cyc_d   = 1'b1;
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                if (bus_fault) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    cti_d   = CTI_CLASSIC;
                    state_d = IDLE;
                end else if (beat_ok) begin
                    adr_d   = adr_q + AW'(4);
                    words_d = words_q - CNT_W'(1);
                    beat_d  = beat_q - BW'(1);
                    if (words_q == CNT_W'(1)) begin
                        cyc_d   = 1'b0;
                        done_d  = 1'b1;
                        cti_d   = CTI_CLASSIC;
                        state_d = IDLE;
                    end else if (beat_q == BW'(1)) begin
                        cyc_d   = 1'b0;
                        state_d = GAP;
                    end else if (beat_q == BW'(2)) begin
                        // The upcoming beat is the last of this burst.
                        cti_d = CTI_EOB;
                    end
                end
            end
            GAP: begin
                beat_d  = burst_beats(words_q);
                cti_d   = first_cti(burst_beats(words_q));
                cyc_d   = 1'b1;
                state_d = BURST;
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = wr_data_i;
    assign wb_sel_o    = '1;
    assign wb_we_o     = we_q;
    assign wb_bte_o    = BTE_LINEAR;
    assign wb_cti_o    = cti_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = stb;
    assign wr_ready_o  = we_q & beat_ok;
    assign rd_valid_o  = ~we_q & beat_ok;
    assign rd_data_o   = wb_dat_i;

endmodule
